// File: rtl/stall_hs_multi.sv
// Multi-channel stall request/acknowledge handshake controller with timeout and abort.
// Latency: first request is registered one cycle after start; done/timeout pulse one cycle after the deciding edge.
// Backpressure: none; start is only sampled in IDLE and ignored otherwise, acks are level-sampled every cycle.
//
// Ports:
//   lclk, sys_rst        clock, asynchronous active-low reset
//   i_stall_start        level start request, sampled in IDLE only
//   i_stall_abort        abandon the handshake in progress (no done/timeout pulse)
//   i_ch_en              channels taking part, latched at start
//   i_lp_stallack        per-channel stall acknowledge
//   o_pl_stallreq        per-channel stall request (registered)
//   o_stall_done         one-cycle pulse on successful completion
//   o_stall_timeout      one-cycle pulse on timeout
//   o_busy               high whenever the FSM is not IDLE
//   o_ack_mask           sticky record of enabled channels that acknowledged this handshake
module stall_hs_multi #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic              lclk,
    input  logic              sys_rst,
    input  logic              i_stall_start,
    input  logic              i_stall_abort,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic [NUM_CH-1:0] i_lp_stallack,
    output logic [NUM_CH-1:0] o_pl_stallreq,
    output logic              o_stall_done,
    output logic              o_stall_timeout,
    output logic              o_busy,
    output logic [NUM_CH-1:0] o_ack_mask
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        ACK_RELEASE = 2'd2
    } state_t;

    // The counter is cleared on entry to REQ, so it holds TMO_MAX-1 in the
    // cycle whose closing edge takes it to TMO_MAX; that edge fires the timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] en_mask;
    logic [NUM_CH-1:0] en_mask_nxt;
    logic [NUM_CH-1:0] ack_mask_nxt;
    logic [NUM_CH-1:0] stallreq_nxt;
    logic [TMO_W-1:0]  cnt;
    logic [TMO_W-1:0]  cnt_nxt;
    logic              done_nxt;
    logic              timeout_nxt;

    logic [NUM_CH-1:0] ack_live;
    logic [NUM_CH-1:0] ack_acc;
    logic              start_ok;
    logic              tmo_hit;

    // Acks on channels outside en_mask never contribute anywhere.
    assign ack_live = i_lp_stallack & en_mask;
    // Includes this cycle's acks so the last ack completes REQ on the same edge.
    assign ack_acc  = o_ack_mask | ack_live;
    // Refuse to start while any participating channel is still acknowledging
    // from a previous handshake.
    assign start_ok = i_stall_start && (|i_ch_en) && ((i_lp_stallack & i_ch_en) == '0);
    assign tmo_hit  = (cnt == TMO_LAST);
    assign o_busy   = (state != IDLE);

    // State and datapath registers
    always_ff @(posedge lclk or negedge sys_rst) begin
        if (!sys_rst) begin
            state           <= IDLE;
            en_mask         <= '0;
            o_ack_mask      <= '0;
            cnt             <= '0;
            o_pl_stallreq   <= '0;
            o_stall_done    <= 1'b0;
            o_stall_timeout <= 1'b0;
        end else begin
            state           <= state_nxt;
            en_mask         <= en_mask_nxt;
            o_ack_mask      <= ack_mask_nxt;
            cnt             <= cnt_nxt;
            o_pl_stallreq   <= stallreq_nxt;
            o_stall_done    <= done_nxt;
            o_stall_timeout <= timeout_nxt;
        end
    end

    // Next-state logic; priority is abort > release completion > timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = REQ;
            end
            REQ: begin
                if (i_stall_abort)          state_nxt = IDLE;
                else if (tmo_hit)           state_nxt = IDLE;
                else if (ack_acc == en_mask) state_nxt = ACK_RELEASE;
            end
            ACK_RELEASE: begin
                if (i_stall_abort)          state_nxt = IDLE;
                else if (ack_live == '0)    state_nxt = IDLE;
                else if (tmo_hit)           state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        en_mask_nxt  = en_mask;
        ack_mask_nxt = o_ack_mask;
        cnt_nxt      = cnt;
        stallreq_nxt = '0;
        done_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    en_mask_nxt  = i_ch_en;
                    ack_mask_nxt = '0;
                    cnt_nxt      = '0;
                    stallreq_nxt = i_ch_en;
                end
            end
            REQ: begin
                cnt_nxt      = cnt + TMO_W'(1);
                ack_mask_nxt = ack_acc;
                timeout_nxt  = !i_stall_abort && tmo_hit;
                if (state_nxt == REQ) stallreq_nxt = en_mask & ~ack_acc;
            end
            ACK_RELEASE: begin
                cnt_nxt     = cnt + TMO_W'(1);
                done_nxt    = !i_stall_abort && (ack_live == '0);
                timeout_nxt = !i_stall_abort && (ack_live != '0) && tmo_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stall_hs_multi.sv
// Directed bench for stall_hs_multi (NUM_CH=2, TMO_MAX=10).
// Each check compares a packed status word against a hand-computed value:
// {o_pl_stallreq[1:0], o_ack_mask[1:0], o_busy, o_stall_done, o_stall_timeout}.
module tb_stall_hs_multi;

    logic       lclk = 1'b0;
    logic       sys_rst;
    logic       i_stall_start;
    logic       i_stall_abort;
    logic [1:0] i_ch_en;
    logic [1:0] i_lp_stallack;
    logic [1:0] o_pl_stallreq;
    logic       o_stall_done;
    logic       o_stall_timeout;
    logic       o_busy;
    logic [1:0] o_ack_mask;

    int tests = 0;
    int fails = 0;

    stall_hs_multi #(
        .NUM_CH (2),
        .TMO_W  (8),
        .TMO_MAX(10)
    ) dut (
        .lclk           (lclk),
        .sys_rst        (sys_rst),
        .i_stall_start  (i_stall_start),
        .i_stall_abort  (i_stall_abort),
        .i_ch_en        (i_ch_en),
        .i_lp_stallack  (i_lp_stallack),
        .o_pl_stallreq  (o_pl_stallreq),
        .o_stall_done   (o_stall_done),
        .o_stall_timeout(o_stall_timeout),
        .o_busy         (o_busy),
        .o_ack_mask     (o_ack_mask)
    );

    always #5 lclk = ~lclk;

    logic [6:0] status;
    assign status = {o_pl_stallreq, o_ack_mask, o_busy, o_stall_done, o_stall_timeout};

    task automatic chk(input string tag, input logic [6:0] expected);
        tests++;
        assert (status === expected)
        else begin
            fails++;
            $error("FAIL %s: observed req/mask/busy/done/tmo=%b expected %b", tag, status, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change then too.
    task automatic tick;
        @(posedge lclk);
        #1;
    endtask

    initial begin
        sys_rst       = 1'b0;
        i_stall_start = 1'b0;
        i_stall_abort = 1'b0;
        i_ch_en       = 2'b00;
        i_lp_stallack = 2'b00;
        #12;
        chk("reset_state", {2'b00, 2'b00, 3'b000});
        tick;
        chk("reset_held", {2'b00, 2'b00, 3'b000});

        // Two-channel handshake; start offered in the same step reset releases.
        sys_rst       = 1'b1;
        i_stall_start = 1'b1;
        i_ch_en       = 2'b11;
        tick;                                           // t1
        chk("hs_t1_req", {2'b11, 2'b00, 3'b100});
        i_stall_start = 1'b0;
        tick;                                           // t2
        chk("hs_t2_req", {2'b11, 2'b00, 3'b100});
        tick;                                           // t3
        chk("hs_t3_req", {2'b11, 2'b00, 3'b100});
        i_lp_stallack = 2'b01;
        tick;                                           // t4
        chk("hs_t4_ch0_drop", {2'b10, 2'b01, 3'b100});
        tick;                                           // t5
        chk("hs_t5_hold", {2'b10, 2'b01, 3'b100});
        i_lp_stallack = 2'b11;
        tick;                                           // t6
        chk("hs_t6_release", {2'b00, 2'b11, 3'b100});
        tick;                                           // t7
        tick;                                           // t8
        chk("hs_t8_release", {2'b00, 2'b11, 3'b100});
        i_lp_stallack = 2'b00;
        tick;                                           // t9
        chk("hs_t9_done", {2'b00, 2'b11, 3'b010});
        tick;                                           // t10
        chk("hs_t10_idle", {2'b00, 2'b11, 3'b000});

        // Channel 0 only; ack[1] toggles and must be ignored; abort in IDLE is a no-op.
        i_stall_start = 1'b1;
        i_stall_abort = 1'b1;
        i_ch_en       = 2'b01;
        i_lp_stallack = 2'b10;
        tick;
        chk("ch0_start", {2'b01, 2'b00, 3'b100});
        i_stall_start = 1'b0;
        i_stall_abort = 1'b0;
        i_lp_stallack = 2'b00;
        tick;
        chk("ch0_req_a", {2'b01, 2'b00, 3'b100});
        i_lp_stallack = 2'b10;
        tick;
        chk("ch0_req_b", {2'b01, 2'b00, 3'b100});
        i_lp_stallack = 2'b11;
        tick;
        chk("ch0_acked", {2'b00, 2'b01, 3'b100});
        i_lp_stallack = 2'b10;
        tick;
        chk("ch0_done", {2'b00, 2'b01, 3'b010});
        i_lp_stallack = 2'b00;
        tick;
        chk("ch0_idle", {2'b00, 2'b01, 3'b000});

        // Timeout: no acks, start held high while busy (must be ignored).
        i_stall_start = 1'b1;
        i_ch_en       = 2'b11;
        tick;                                           // t1
        chk("tmo_t1", {2'b11, 2'b00, 3'b100});
        for (int i = 2; i <= 10; i++) tick;             // t10
        chk("tmo_t10", {2'b11, 2'b00, 3'b100});
        i_stall_start = 1'b0;
        tick;                                           // t11
        chk("tmo_t11_pulse", {2'b00, 2'b00, 3'b001});
        tick;                                           // t12
        chk("tmo_t12_idle", {2'b00, 2'b00, 3'b000});

        // Abort in the same cycle acks fall in ACK_RELEASE.
        i_stall_start = 1'b1;
        tick;
        chk("abort_req", {2'b11, 2'b00, 3'b100});
        i_stall_start = 1'b0;
        i_lp_stallack = 2'b11;
        tick;
        chk("abort_release", {2'b00, 2'b11, 3'b100});
        i_lp_stallack = 2'b00;
        i_stall_abort = 1'b1;
        tick;
        chk("abort_no_done", {2'b00, 2'b11, 3'b000});

        // Start held with ack[0] still high: stays IDLE until ack[0] falls.
        i_stall_abort = 1'b0;
        i_stall_start = 1'b1;
        i_lp_stallack = 2'b01;
        tick;
        chk("blocked_a", {2'b00, 2'b11, 3'b000});
        tick;
        chk("blocked_b", {2'b00, 2'b11, 3'b000});
        i_lp_stallack = 2'b00;
        tick;
        chk("unblocked_start", {2'b11, 2'b00, 3'b100});
        i_stall_start = 1'b0;

        // Asynchronous reset in REQ with both requests up.
        sys_rst = 1'b0;
        #2;
        chk("async_reset", {2'b00, 2'b00, 3'b000});
        tick;
        chk("async_reset_held", {2'b00, 2'b00, 3'b000});

        // Fresh handshake after reset; ack[0] falls in REQ but its mask bit stays.
        sys_rst       = 1'b1;
        i_stall_start = 1'b1;
        i_ch_en       = 2'b11;
        tick;
        chk("fresh_start", {2'b11, 2'b00, 3'b100});
        i_stall_start = 1'b0;
        i_lp_stallack = 2'b01;
        tick;
        chk("fresh_ack0", {2'b10, 2'b01, 3'b100});
        i_lp_stallack = 2'b10;
        tick;
        chk("fresh_sticky", {2'b00, 2'b11, 3'b100});
        i_lp_stallack = 2'b00;
        tick;
        chk("fresh_done", {2'b00, 2'b11, 3'b010});
        tick;
        chk("fresh_idle", {2'b00, 2'b11, 3'b000});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
